// File: rtl/control_unit_if.sv
// Bus bundle between the multi-cycle control unit and the 16-bit datapath.
// The master side (controller) consumes the instruction and ALU flags and
// produces the full control word. The slave side (datapath) mirrors it.
interface control_unit_if;
  logic [15:0] IR_OUT;
  logic [3:0]  status;
  logic [2:0]  AA;
  logic [2:0]  BA;
  logic [2:0]  DA;
  logic        WR;
  logic [4:0]  FS;
  logic        C0;
  logic [15:0] K;
  logic        BSEL;
  logic        PCSEL;
  logic [1:0]  PS;
  logic        EN_ALU;
  logic        EN_B;
  logic        EN_PC;
  logic        ROM_EN;
  logic        EN_ADDRESS_ALU;
  logic        ENADDRESS_PC;
  logic        IR_EN;
  logic        MW;
  logic        MR;
  logic [2:0]  state;
  logic        halted;
  logic        illegal;

  modport master (
    input  IR_OUT, status,
    output AA, BA, DA, WR, FS, C0, K, BSEL, PCSEL, PS,
           EN_ALU, EN_B, EN_PC, ROM_EN, EN_ADDRESS_ALU, ENADDRESS_PC,
           IR_EN, MW, MR, state, halted, illegal
  );

  modport slave (
    output IR_OUT, status,
    input  AA, BA, DA, WR, FS, C0, K, BSEL, PCSEL, PS,
           EN_ALU, EN_B, EN_PC, ROM_EN, EN_ADDRESS_ALU, ENADDRESS_PC,
           IR_EN, MW, MR, state, halted, illegal
  );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle control unit for the 16-bit datapath.
// Sequences FETCH, DECODE, EXEC and (for loads) MEM, and drives every select,
// enable and write strobe from the current state and the instruction register.
// Optional feature: define CU_LINK_EN to turn opcode 0xB into BL imm12, which
// saves the already-incremented PC into R7 while loading the branch target.
// Without it, opcode 0xB is undefined and runs as a NOP with an illegal pulse.
module control_unit (
  input  logic           clk,
  input  logic           reset,
  control_unit_if.master bus
);

  localparam logic [4:0] FS_ADD   = 5'b00100;
  localparam logic [4:0] FS_SUB   = 5'b00101;
  localparam logic [4:0] FS_AND   = 5'b00000;
  localparam logic [4:0] FS_OR    = 5'b00001;
  localparam logic [4:0] FS_PASSA = 5'b01100;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_B    = 4'h8;
  localparam logic [3:0] OP_BZ   = 4'h9;
  localparam logic [3:0] OP_BNZ  = 4'hA;
  localparam logic [3:0] OP_BL   = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] LINK_REG = 3'd7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_ADDI,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_LINK,
    CLS_HALT,
    CLS_ILLEGAL
  } class_t;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  flags_q;
  logic        unused_flags;

  logic [3:0]  op;
  logic [2:0]  rd;
  logic [2:0]  ra;
  logic [2:0]  rb;
  logic [15:0] imm6_k;
  logic [15:0] imm12_k;

  class_t      cls;
  logic [4:0]  alu_fs;
  logic        alu_c0;
  logic        branch_taken;
  logic        flag_load;

  logic [2:0]  aa;
  logic [2:0]  ba;
  logic [2:0]  da;
  logic        wr;
  logic [4:0]  fs;
  logic        c0;
  logic [15:0] k;
  logic        bsel;
  logic        pcsel;
  logic [1:0]  ps;
  logic        en_alu;
  logic        en_b;
  logic        en_pc;
  logic        rom_en;
  logic        en_address_alu;
  logic        enaddress_pc;
  logic        ir_en;
  logic        mw;
  logic        mr;
  logic        halted;
  logic        illegal;

  assign op      = bus.IR_OUT[15:12];
  assign rd      = bus.IR_OUT[11:9];
  assign ra      = bus.IR_OUT[8:6];
  assign rb      = bus.IR_OUT[5:3];
  assign imm6_k  = {10'd0, bus.IR_OUT[5:0]};
  assign imm12_k = {4'd0, bus.IR_OUT[11:0]};

  // V, C and N are latched alongside Z for future condition codes; only Z steers branches today.
  assign unused_flags = ^flags_q[3:1];

  // Classify the opcode and pick the ALU function for the register-register group.
  always_comb begin
    cls    = CLS_ILLEGAL;
    alu_fs = FS_ADD;
    alu_c0 = 1'b0;
    case (op)
      OP_NOP:  cls = CLS_NOP;
      OP_ADD:  begin cls = CLS_ALU; alu_fs = FS_ADD; end
      OP_SUB:  begin cls = CLS_ALU; alu_fs = FS_SUB; alu_c0 = 1'b1; end
      OP_AND:  begin cls = CLS_ALU; alu_fs = FS_AND; end
      OP_OR:   begin cls = CLS_ALU; alu_fs = FS_OR;  end
      OP_ADDI: cls = CLS_ADDI;
      OP_LD:   cls = CLS_LOAD;
      OP_ST:   cls = CLS_STORE;
      OP_B,
      OP_BZ,
      OP_BNZ:  cls = CLS_BRANCH;
`ifdef CU_LINK_EN
      OP_BL:   cls = CLS_LINK;
`else
      OP_BL:   cls = CLS_ILLEGAL;
`endif
      OP_HALT: cls = CLS_HALT;
      default: cls = CLS_ILLEGAL;
    endcase
  end

  // Resolve branch direction from the Z flag captured by the last ALU instruction.
  always_comb begin
    branch_taken = 1'b0;
    case (op)
      OP_B:    branch_taken = 1'b1;
      OP_BZ:   branch_taken = flags_q[0];
      OP_BNZ:  branch_taken = ~flags_q[0];
      default: branch_taken = 1'b0;
    endcase
  end

  assign flag_load = (state_q == EXEC) && ((cls == CLS_ALU) || (cls == CLS_ADDI));

  // Next-state sequencing: loads take an extra MEM cycle, HALT parks until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   state_d = DECODE;
      DECODE:  state_d = EXEC;
      EXEC: begin
        if (cls == CLS_LOAD) begin
          state_d = MEM;
        end else if (cls == CLS_HALT) begin
          state_d = HALT;
        end else begin
          state_d = FETCH;
        end
      end
      MEM:     state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // State and flag registers; a low reset wins over any flag update in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      flags_q <= 4'd0;
    end else begin
      state_q <= state_d;
      if (flag_load) begin
        flags_q <= bus.status;
      end
    end
  end

  // Control word decode: everything defaults to 0 and each phase raises only what it needs.
  always_comb begin
    aa             = 3'd0;
    ba             = 3'd0;
    da             = 3'd0;
    wr             = 1'b0;
    fs             = 5'd0;
    c0             = 1'b0;
    k              = 16'd0;
    bsel           = 1'b0;
    pcsel          = 1'b0;
    ps             = 2'b00;
    en_alu         = 1'b0;
    en_b           = 1'b0;
    en_pc          = 1'b0;
    rom_en         = 1'b0;
    en_address_alu = 1'b0;
    enaddress_pc   = 1'b0;
    ir_en          = 1'b0;
    mw             = 1'b0;
    mr             = 1'b0;
    halted         = 1'b0;
    illegal        = 1'b0;
    case (state_q)
      FETCH: begin
        enaddress_pc = 1'b1;
        rom_en       = 1'b1;
        ir_en        = 1'b1;
        ps           = 2'b01;
      end
      DECODE: begin
        aa = ra;
        ba = rb;
      end
      EXEC: begin
        case (cls)
          CLS_ALU: begin
            aa     = ra;
            ba     = rb;
            da     = rd;
            wr     = 1'b1;
            en_alu = 1'b1;
            fs     = alu_fs;
            c0     = alu_c0;
          end
          CLS_ADDI: begin
            aa     = ra;
            da     = rd;
            wr     = 1'b1;
            en_alu = 1'b1;
            fs     = FS_ADD;
            bsel   = 1'b1;
            k      = imm6_k;
          end
          CLS_LOAD: begin
            aa             = ra;
            fs             = FS_PASSA;
            en_address_alu = 1'b1;
            mr             = 1'b1;
          end
          CLS_STORE: begin
            aa             = ra;
            ba             = rb;
            fs             = FS_PASSA;
            en_address_alu = 1'b1;
            en_b           = 1'b1;
            mw             = 1'b1;
          end
          CLS_BRANCH: begin
            if (branch_taken) begin
              pcsel = 1'b1;
              k     = imm12_k;
              ps    = 2'b10;
            end
          end
          CLS_LINK: begin
            en_pc = 1'b1;
            wr    = 1'b1;
            da    = LINK_REG;
            pcsel = 1'b1;
            k     = imm12_k;
            ps    = 2'b10;
          end
          CLS_ILLEGAL: begin
            illegal = 1'b1;
          end
          default: begin
          end
        endcase
      end
      MEM: begin
        aa             = ra;
        fs             = FS_PASSA;
        en_address_alu = 1'b1;
        mr             = 1'b1;
        wr             = 1'b1;
        da             = rd;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.AA             = aa;
  assign bus.BA             = ba;
  assign bus.DA             = da;
  assign bus.WR             = wr;
  assign bus.FS             = fs;
  assign bus.C0             = c0;
  assign bus.K              = k;
  assign bus.BSEL           = bsel;
  assign bus.PCSEL          = pcsel;
  assign bus.PS             = ps;
  assign bus.EN_ALU         = en_alu;
  assign bus.EN_B           = en_b;
  assign bus.EN_PC          = en_pc;
  assign bus.ROM_EN         = rom_en;
  assign bus.EN_ADDRESS_ALU = en_address_alu;
  assign bus.ENADDRESS_PC   = enaddress_pc;
  assign bus.IR_EN          = ir_en;
  assign bus.MW             = mw;
  assign bus.MR             = mr;
  assign bus.state          = state_q;
  assign bus.halted         = halted;
  assign bus.illegal        = illegal;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: each instruction is expanded into the
// list of control words it must produce cycle by cycle, and a compare process
// checks the DUT against that list on every clocked cycle.
module tb_control_unit;

  typedef struct packed {
    logic [2:0]  AA;
    logic [2:0]  BA;
    logic [2:0]  DA;
    logic        WR;
    logic [4:0]  FS;
    logic        C0;
    logic [15:0] K;
    logic        BSEL;
    logic        PCSEL;
    logic [1:0]  PS;
    logic        EN_ALU;
    logic        EN_B;
    logic        EN_PC;
    logic        ROM_EN;
    logic        EN_ADDRESS_ALU;
    logic        ENADDRESS_PC;
    logic        IR_EN;
    logic        MW;
    logic        MR;
    logic [2:0]  state;
    logic        halted;
    logic        illegal;
  } ctl_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  control_unit_if bus();

  control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int    vectors = 0;
  int    miscompares = 0;
  ctl_t  exp_word = '0;
  string exp_name = "";
  bit    exp_valid = 1'b0;
  logic  model_z = 1'b0;

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  function automatic ctl_t blank(input logic [2:0] st);
    ctl_t w;
    w = '0;
    w.state = st;
    return w;
  endfunction

  function automatic ctl_t idle_word();
    return blank(3'd0);
  endfunction

  function automatic ctl_t fetch_word();
    ctl_t w;
    w = blank(3'd1);
    w.ENADDRESS_PC = 1'b1;
    w.ROM_EN = 1'b1;
    w.IR_EN = 1'b1;
    w.PS = 2'b01;
    return w;
  endfunction

  function automatic ctl_t decode_word(input logic [15:0] ir);
    ctl_t w;
    w = blank(3'd2);
    w.AA = ir[8:6];
    w.BA = ir[5:3];
    return w;
  endfunction

  function automatic ctl_t exec_word(input logic [15:0] ir, input logic z);
    ctl_t w;
    int   op;
    bit   taken;
    w = blank(3'd3);
    op = int'(ir[15:12]);
    if (op >= 1 && op <= 4) begin
      w.AA = ir[8:6]; w.BA = ir[5:3]; w.DA = ir[11:9];
      w.WR = 1'b1; w.EN_ALU = 1'b1;
      w.FS = (op == 1) ? 5'b00100 : (op == 2) ? 5'b00101 : (op == 3) ? 5'b00000 : 5'b00001;
      w.C0 = (op == 2);
    end else if (op == 5) begin
      w.AA = ir[8:6]; w.DA = ir[11:9]; w.WR = 1'b1; w.EN_ALU = 1'b1;
      w.FS = 5'b00100; w.BSEL = 1'b1; w.K = {10'd0, ir[5:0]};
    end else if (op == 6) begin
      w.FS = 5'b01100; w.AA = ir[8:6]; w.EN_ADDRESS_ALU = 1'b1; w.MR = 1'b1;
    end else if (op == 7) begin
      w.FS = 5'b01100; w.AA = ir[8:6]; w.BA = ir[5:3];
      w.EN_ADDRESS_ALU = 1'b1; w.EN_B = 1'b1; w.MW = 1'b1;
    end else if (op >= 8 && op <= 10) begin
      taken = (op == 8) || (op == 9 && z) || (op == 10 && !z);
      if (taken) begin
        w.PCSEL = 1'b1; w.K = {4'd0, ir[11:0]}; w.PS = 2'b10;
      end
    end else if (op == 11) begin
`ifdef CU_LINK_EN
      w.EN_PC = 1'b1; w.WR = 1'b1; w.DA = 3'd7;
      w.PCSEL = 1'b1; w.K = {4'd0, ir[11:0]}; w.PS = 2'b10;
`else
      w.illegal = 1'b1;
`endif
    end else if (op >= 12 && op <= 14) begin
      w.illegal = 1'b1;
    end
    return w;
  endfunction

  function automatic ctl_t mem_word(input logic [15:0] ir);
    ctl_t w;
    w = blank(3'd4);
    w.FS = 5'b01100; w.AA = ir[8:6]; w.EN_ADDRESS_ALU = 1'b1; w.MR = 1'b1;
    w.WR = 1'b1; w.DA = ir[11:9];
    return w;
  endfunction

  function automatic ctl_t halt_word();
    ctl_t w;
    w = blank(3'd5);
    w.halted = 1'b1;
    return w;
  endfunction

  function automatic ctl_t observed();
    ctl_t w;
    w.AA = bus.AA; w.BA = bus.BA; w.DA = bus.DA; w.WR = bus.WR;
    w.FS = bus.FS; w.C0 = bus.C0; w.K = bus.K; w.BSEL = bus.BSEL;
    w.PCSEL = bus.PCSEL; w.PS = bus.PS; w.EN_ALU = bus.EN_ALU; w.EN_B = bus.EN_B;
    w.EN_PC = bus.EN_PC; w.ROM_EN = bus.ROM_EN; w.EN_ADDRESS_ALU = bus.EN_ADDRESS_ALU;
    w.ENADDRESS_PC = bus.ENADDRESS_PC; w.IR_EN = bus.IR_EN; w.MW = bus.MW;
    w.MR = bus.MR; w.state = bus.state; w.halted = bus.halted; w.illegal = bus.illegal;
    return w;
  endfunction

  task automatic checkOutput(input ctl_t got, input ctl_t want, input string nm);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got state=%0d word=%h, want state=%0d word=%h",
               nm, $time, got.state, got, want.state, want);
    end
  endtask

  task automatic checkInvariants(input ctl_t got);
    int data_drivers;
    int addr_drivers;
    data_drivers = int'(got.EN_ALU) + int'(got.EN_B) + int'(got.EN_PC) + int'(got.ROM_EN) + int'(got.MR);
    addr_drivers = int'(got.EN_ADDRESS_ALU) + int'(got.ENADDRESS_PC);
    vectors++;
    if (data_drivers > 1 || addr_drivers > 1 || (got.MW && got.MR)) begin
      miscompares++;
      $display("[TB] FAIL bus_contention at %0t: data=%0d addr=%0d mw=%0b mr=%0b, want data<=1 addr<=1 not both",
               $time, data_drivers, addr_drivers, got.MW, got.MR);
    end
  endtask

  // Compare process: checks the live control word against the expectation for this cycle.
  always @(negedge clk) begin
    if (exp_valid) begin
      checkOutput(observed(), exp_word, exp_name);
      checkInvariants(observed());
    end
  end

  // Publish the expectation for the current cycle, then advance one clock.
  task automatic step(input ctl_t w, input string nm, input logic [3:0] st);
    bus.status = st;
    exp_word = w;
    exp_name = nm;
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Pull reset low in a cycle showing 'current', hold it 'extra' more cycles, then release.
  task automatic resetSequence(input ctl_t current, input string nm, input int extra);
    reset = 1'b0;
    step(current, nm, 4'($urandom));
    for (int i = 0; i < extra; i++) step(idle_word(), "reset_idle", 4'($urandom));
    reset = 1'b1;
    step(idle_word(), "release_idle", 4'($urandom));
    model_z = 1'b0;
  endtask

  // Run one instruction from FETCH to its last cycle, optionally aborted by reset at record abort_at.
  task automatic applyStimulus(input logic [15:0] ir, input logic [3:0] st, input int abort_at);
    ctl_t  recs[$];
    string names[$];
    int    op;
    op = int'(ir[15:12]);
    recs.push_back(fetch_word());         names.push_back("fetch");
    recs.push_back(decode_word(ir));      names.push_back("decode");
    recs.push_back(exec_word(ir, model_z)); names.push_back($sformatf("exec_%h", ir));
    if (op == 6) begin
      recs.push_back(mem_word(ir));       names.push_back($sformatf("mem_%h", ir));
    end
    for (int i = 0; i < recs.size(); i++) begin
      if (i == 1) bus.IR_OUT = ir;
      if (i == abort_at) begin
        resetSequence(recs[i], names[i], int'($urandom_range(0, 1)));
        return;
      end
      step(recs[i], names[i], (i == 2) ? st : 4'($urandom));
      if (i == 2 && op >= 1 && op <= 5) model_z = st[0];
    end
    if (op == 15) begin
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) step(halt_word(), "halt", 4'($urandom));
      resetSequence(halt_word(), "halt_reset", int'($urandom_range(0, 1)));
    end
  endtask

  task automatic pinModel(input ctl_t got, input ctl_t want, input string nm);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: model gives %h, hand value %h", nm, got, want);
    end
  endtask

  // Watchdog so a stuck run still ends with a visible failure.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus: pin the model with hand-worked words, run the directed program, then random traffic.
  initial begin
    ctl_t lit;
    logic [3:0] op;
    int abort_at;

    lit = '0; lit.state = 3'd1; lit.ENADDRESS_PC = 1; lit.ROM_EN = 1; lit.IR_EN = 1; lit.PS = 2'b01;
    pinModel(fetch_word(), lit, "pin_fetch");
    lit = '0; lit.state = 3'd3; lit.FS = 5'b00100; lit.AA = 3'd2; lit.BA = 3'd3; lit.DA = 3'd1;
    lit.WR = 1; lit.EN_ALU = 1;
    pinModel(exec_word(16'h1298, 1'b0), lit, "pin_add");
    lit = '0; lit.state = 3'd3; lit.PCSEL = 1; lit.K = 16'h0040; lit.PS = 2'b10;
    pinModel(exec_word(16'h9040, 1'b1), lit, "pin_bz_taken");
    lit = '0; lit.state = 3'd3;
    pinModel(exec_word(16'h9040, 1'b0), lit, "pin_bz_not_taken");
    lit = '0; lit.state = 3'd3; lit.FS = 5'b01100; lit.AA = 3'd5; lit.EN_ADDRESS_ALU = 1; lit.MR = 1;
    pinModel(exec_word(16'h6940, 1'b0), lit, "pin_ld_exec");
    lit.state = 3'd4; lit.WR = 1; lit.DA = 3'd4;
    pinModel(mem_word(16'h6940), lit, "pin_ld_mem");
    lit = '0; lit.state = 3'd3; lit.FS = 5'b01100; lit.AA = 3'd2; lit.BA = 3'd3;
    lit.EN_ADDRESS_ALU = 1; lit.EN_B = 1; lit.MW = 1;
    pinModel(exec_word(16'h7098, 1'b0), lit, "pin_st");
    lit = '0; lit.state = 3'd3; lit.illegal = 1;
    pinModel(exec_word(16'hC000, 1'b0), lit, "pin_illegal");
`ifdef CU_LINK_EN
    lit = '0; lit.state = 3'd3; lit.EN_PC = 1; lit.WR = 1; lit.DA = 3'd7; lit.PCSEL = 1;
    lit.K = 16'h0123; lit.PS = 2'b10;
    pinModel(exec_word(16'hB123, 1'b0), lit, "pin_bl");
`endif

    bus.IR_OUT = 16'h0000;
    bus.status = 4'h0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    step(idle_word(), "reset_idle", 4'h0);
    reset = 1'b1;
    step(idle_word(), "release_idle", 4'h0);

    applyStimulus(16'h2298, 4'b0001, -1);
    applyStimulus(16'h9040, 4'b0000, -1);
    applyStimulus(16'h1298, 4'b0000, -1);
    applyStimulus(16'h9040, 4'b0001, -1);
    applyStimulus(16'hA040, 4'b0000, -1);
    applyStimulus(16'h6940, 4'b1111, -1);
    applyStimulus(16'h7098, 4'b0000, -1);
    applyStimulus(16'h5A7F, 4'b0001, -1);
    applyStimulus(16'h9FFF, 4'b0000, -1);
    applyStimulus(16'hC000, 4'b1111, -1);
    applyStimulus(16'hB123, 4'b0000, -1);
    applyStimulus(16'h1298, 4'b0001, 2);
    applyStimulus(16'h9040, 4'b0000, -1);
    applyStimulus(16'hF000, 4'b0000, -1);

    for (int n = 0; n < 600; n++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h1;
      abort_at = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 2)) : -1;
      applyStimulus({op, 12'($urandom)}, 4'($urandom), abort_at);
    end

    exp_valid = 1'b0;
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle control unit that drives the 16-bit datapath's control word from the fetched instruction and ALU status. It sequences fetch (ROM via PC), decode, execute and memory phases. It consumes IR_OUT and status from the datapath and produces every select, enable and write strobe the datapath takes as input.

## Interface
- FS_ADD, 5'b00100, ALU function code for add
- FS_SUB, 5'b00101, ALU function code for subtract (C0=1 also driven)
- FS_AND, 5'b00000, ALU function code for AND
- FS_OR, 5'b00001, ALU function code for OR
- FS_PASSA, 5'b01100, ALU function code passing A to F
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low; all state and flags clear on the rising edge of clk while low
- IR_OUT  in  16  current instruction from the instruction register
- status  in  4  ALU flags {V,C,N,Z}
- AA, BA, DA  out  3 each  register file A/B read and destination addresses
- WR  out  1  register file write enable
- FS  out  5  ALU function select; C0 out 1 carry-in
- K  out  16  constant to B mux and PC mux
- BSEL, PCSEL  out  1 each  K-select for B bus and PC input
- PS  out  2  PC op: 00 hold, 01 increment, 10 load PCIN; 11 never driven
- EN_ALU, EN_B, EN_PC, ROM_EN  out  1 each  data-bus drivers
- EN_ADDRESS_ALU, ENADDRESS_PC  out  1 each  address-bus drivers
- IR_EN, MW, MR  out  1 each  IR load, RAM write, RAM read
- state  out  3  current FSM state (visualisation)
- halted  out  1  high in HALT; illegal  out  1  one-cycle pulse on undefined opcode

## Operation
- Encoding: op=IR[15:12], rd=IR[11:9], ra=IR[8:6], rb=IR[5:3], imm6=IR[5:0] zero-extended, imm12=IR[11:0] zero-extended to K.
- Opcodes: 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR (rd=ra op rb); 5 ADDI (rd=ra+imm6, BSEL=1, K=imm6); 6 LD rd,[ra]; 7 ST [ra],rb; 8 B imm12; 9 BZ imm12; A BNZ imm12; F HALT; all others illegal, executed as NOP.
- States: IDLE(0), FETCH(1), DECODE(2), EXEC(3), MEM(4), HALT(5). Outputs are combinational from state and IR_OUT; any output not listed is 0.
- IDLE: all outputs 0; next FETCH.
- FETCH: ENADDRESS_PC=1, ROM_EN=1, IR_EN=1, PS=01; next DECODE.
- DECODE: AA=ra, BA=rb driven, no enables; next EXEC.
- EXEC ALU/ADDI: FS per op, EN_ALU=1, WR=1, DA=rd; flag register Z,N,C,V latches status at the edge; next FETCH.
- EXEC LD: FS=FS_PASSA, AA=ra, EN_ADDRESS_ALU=1, MR=1; next MEM. MEM: same address and MR held, WR=1, DA=rd; next FETCH.
- EXEC ST: FS=FS_PASSA, AA=ra, BA=rb, EN_ADDRESS_ALU=1, EN_B=1, MW=1; next FETCH.
- EXEC B: PCSEL=1, K=imm12, PS=10. BZ/BNZ: same if latched Z=1 / Z=0, otherwise PS=00. Next FETCH.
- EXEC HALT: next HALT; HALT holds all outputs 0 and halted=1 until reset.
- Invariants: at most one data-bus driver (EN_ALU, EN_B, EN_PC, ROM_EN, MR) per cycle; at most one address-bus driver per cycle; MW and MR never both high.

## Timing
- Reset low at an edge: state=IDLE, flags=0, all outputs 0 the following cycle. Reset mid-instruction aborts with no WR/MW issued after that edge.
- CPI: ALU/ADDI/ST/B/BZ/BNZ/NOP = 3 cycles (FETCH, DECODE, EXEC); LD = 4.
- PC increments at the end of FETCH, so branch targets are absolute and not PC-relative.
- Flags change only on ALU/ADDI EXEC. LD, ST and branches preserve them.
- illegal pulses for the EXEC cycle only; flags untouched.
- PC wrap from 0xFFFF to 0x0000 is the datapath's concern; the controller continues unchanged.

## Configuration
- CU_LINK_EN defined: opcode B = BL imm12. EXEC drives EN_PC=1, WR=1, DA=3'd7, PCSEL=1, K=imm12, PS=10, so R7 receives the return address (already-incremented PC) and PC loads the target in one cycle.
- Undefined: opcode B is illegal and handled as NOP with an illegal pulse.

## Test plan
- Reset held 2 cycles then released -> state IDLE then FETCH; first FETCH has ENADDRESS_PC=ROM_EN=IR_EN=1, PS=01.
- IR=0x1298 (ADD R1,R2,R3) -> EXEC: FS=FS_ADD, AA=2, BA=3, DA=1, WR=1, EN_ALU=1; 3 cycles to next FETCH.
- SUB with status=4'b0001, then BZ 0x040 -> PCSEL=1, K=0x0040, PS=10; with Z=0, BZ gives PS=00.
- LD R4,[R5] -> EXEC MR=1, EN_ADDRESS_ALU=1, WR=0; MEM WR=1, DA=4; 4-cycle CPI. ST -> MW=1, EN_B=1, no WR.
- IR=0xC000 -> illegal=1 for one cycle, no WR/MW; IR=0xF000 -> halted=1 and outputs 0 until reset low.
- CU_LINK_EN build: IR=0xB123 -> EN_PC=1, DA=7, WR=1, K=0x0123, PS=10 in the same EXEC cycle.
